// File: rtl/fifo_modport.sv
// Single-clock byte FIFO with active-low write/read strobes and overflow/underflow flags.
// Latency: registered read data appears on dout one cycle after the sampled read strobe.
// Backpressure: none; a write to a full FIFO is dropped (over_flow), a read of an empty FIFO is ignored (under_flow).
// Build option: define FIFO_STICKY_ERR_EN to make under_flow/over_flow sticky until rst.
module fifo_modport #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_n,
    input  logic                  rd_n,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  under_flow,
    output logic                  over_flow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  under_flow_q, under_flow_d;
    logic                  over_flow_q, over_flow_d;

    logic full, empty;
    logic rd_ok, wr_ok;
    logic uf_evt, of_evt;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A read needs data; a write needs room, or a concurrent read freeing a slot.
    assign rd_ok  = !rd_n && !empty;
    assign wr_ok  = !wr_n && (!full || rd_ok);
    assign uf_evt = !rd_n && empty;
    assign of_evt = !wr_n && full && rd_n;

    // Next-state for pointers, occupancy, read data and error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

`ifdef FIFO_STICKY_ERR_EN
        under_flow_d = under_flow_q | uf_evt;
        over_flow_d  = over_flow_q  | of_evt;
`else
        under_flow_d = uf_evt;
        over_flow_d  = of_evt;
`endif
    end

    // Control state and outputs, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            under_flow_q <= 1'b0;
            over_flow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            under_flow_q <= under_flow_d;
            over_flow_q  <= over_flow_d;
        end
    end

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign under_flow = under_flow_q;
    assign over_flow  = over_flow_q;

endmodule

// File: tb/tb_fifo_modport.sv
// Self-checking bench for fifo_modport: directed scenarios plus random traffic
// compared against a queue-based reference model of the FIFO's observable behaviour.
// Build with FIFO_STICKY_ERR_EN defined to exercise the sticky-flag variant.
module tb_fifo_modport;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_n = 1'b1;
    logic          rd_n = 1'b1;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          under_flow;
    logic          over_flow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout = '0;
    logic          exp_uf   = 1'b0;
    logic          exp_of   = 1'b0;

    fifo_modport #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_n       (wr_n),
        .rd_n       (rd_n),
        .din        (din),
        .dout       (dout),
        .under_flow (under_flow),
        .over_flow  (over_flow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout"}, dout, exp_dout);
        chk({tag, ".uf"}, {7'b0, under_flow}, {7'b0, exp_uf});
        chk({tag, ".of"}, {7'b0, over_flow}, {7'b0, exp_of});
    endtask

    // Apply one cycle of strobes, advance the model, then check the outputs.
    task automatic step(input bit do_wr, input bit do_rd, input logic [DW-1:0] d, input string tag);
        bit uf, of;
        @(negedge clk);
        wr_n = !do_wr;
        rd_n = !do_rd;
        din  = d;
        @(posedge clk);
        uf = do_rd && (q.size() == 0);
        of = do_wr && (q.size() == DEPTH) && !do_rd;
        if (do_rd && q.size() > 0) exp_dout = q.pop_front();
        if (do_wr && q.size() < DEPTH) q.push_back(d);
        exp_uf = STICKY ? (exp_uf | uf) : uf;
        exp_of = STICKY ? (exp_of | of) : of;
        #1;
        chk_all(tag);
        @(negedge clk);
        wr_n = 1'b1;
        rd_n = 1'b1;
    endtask

    // Asynchronous reset: checked before any clock edge can act.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        exp_dout = '0;
        exp_uf   = 1'b0;
        exp_of   = 1'b0;
        chk_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // T1: reset state, then a read on empty
        #1;
        chk_all("t1_rst");
        chk("t1_rst_const", dout, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 8'h00, "t1_rd_empty");
        chk("t1_uf_const", {7'b0, under_flow}, 8'h01);
        step(0, 0, 8'h00, "t1_idle");

        // T2: ordering
        do_reset("t2_rst");
        step(1, 0, 8'h11, "t2_w");
        step(1, 0, 8'h22, "t2_w");
        step(1, 0, 8'h33, "t2_w");
        step(0, 1, 8'h00, "t2_r");
        chk("t2_first", dout, 8'h11);
        step(0, 1, 8'h00, "t2_r");
        step(0, 1, 8'h00, "t2_r");
        chk("t2_last", dout, 8'h33);

        // T3: overflow
        do_reset("t3_rst");
        for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i), "t3_fill");
        step(1, 0, 8'hAA, "t3_ovf");
        chk("t3_of_const", {7'b0, over_flow}, 8'h01);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 8'h00, "t3_drain");
            chk("t3_drain_val", dout, DW'(i));
        end
        step(0, 1, 8'h00, "t3_empty_rd");

        // T4: wrap
        do_reset("t4_rst");
        for (int i = 0; i < 40; i++) begin
            step(1, 0, DW'(i), "t4_w");
            step(0, 1, 8'h00, "t4_r");
        end
        chk("t4_last", dout, 8'd39);

        // T5: simultaneous on full, then on empty
        do_reset("t5_rst");
        for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(8'h80 + i), "t5_fill");
        step(1, 1, 8'h5A, "t5_full_both");
        chk("t5_oldest", dout, 8'h80);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, "t5_drain");
        chk("t5_last_5a", dout, 8'h5A);
        do_reset("t5_rst2");
        step(1, 1, 8'hC3, "t5_empty_both");
        step(0, 1, 8'h00, "t5_after");
        chk("t5_written", dout, 8'hC3);

        // Random traffic with occasional mid-operation reset
        do_reset("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_midrst");
            end else begin
                step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45),
                     DW'($urandom), "rnd");
            end
        end

`ifdef FIFO_STICKY_ERR_EN
        // T6: sticky flags persist until reset
        do_reset("t6_rst");
        step(0, 1, 8'h00, "t6_rd_empty");
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00, "t6_idle");
            chk("t6_sticky", {7'b0, under_flow}, 8'h01);
        end
        do_reset("t6_clear");
        chk("t6_cleared", {7'b0, under_flow}, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
